// File: rtl/mem_stage.sv
// MEM stage of the 5-stage pipeline: data-memory req/ready handshake, store lane
// alignment, load extraction, stall request and the MEM/WB pipeline register.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EXMEMInstruction,
  input  logic [31:0] EXMEMPCPlus4,
  input  logic [31:0] EXMEMALUResult,
  input  logic [31:0] EXMEMMemWriteData,
  input  logic [4:0]  EXMEMRegRd,
  input  logic        EXMEMRegWrite,
  input  logic        EXMEMMemWrite,
  input  logic [1:0]  EXMEMMemWrBits,
  input  logic        EXMEMMemRead,
  input  logic [2:0]  EXMEMMemRBits,
  input  logic [1:0]  EXMEMMemtoReg,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [3:0]  DMemByteEn,
  output logic [31:0] DMemWData,
  input  logic [31:0] DMemRData,
  input  logic        DMemReady,
  output logic        MEMStallReq,
  output logic        MisalignErr,
  output logic [31:0] MEMWBInstruction,
  output logic [31:0] MEMWBWriteData,
  output logic [4:0]  MEMWBRegRd,
  output logic        MEMWBRegWrite
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        regwrite_q, regwrite_d;
  logic        misalign_q, misalign_d;

  logic [1:0]  addr_lo_s;
  logic        access_s;
  logic        is_half_s;
  logic        is_byte_s;
  logic        misalign_s;
  logic        req_s;
  logic        stall_s;
  logic [3:0]  byte_en_s;
  logic [31:0] store_data_s;
  logic [7:0]  load_byte_s;
  logic [15:0] load_half_s;
  logic [31:0] load_data_s;
  logic [31:0] result_s;

  assign addr_lo_s = EXMEMALUResult[1:0];
  assign access_s  = EXMEMMemRead | EXMEMMemWrite;

  // Access size decode; a store's size wins if both strobes are somehow set.
  always_comb begin
    is_half_s = 1'b0;
    is_byte_s = 1'b0;
    if (EXMEMMemWrite) begin
      case (EXMEMMemWrBits)
        2'b01:   is_half_s = 1'b1;
        2'b10:   is_byte_s = 1'b1;
        default: begin
          is_half_s = 1'b0;
          is_byte_s = 1'b0;
        end
      endcase
    end else begin
      case (EXMEMMemRBits)
        3'b001, 3'b010: is_half_s = 1'b1;
        3'b011, 3'b100: is_byte_s = 1'b1;
        default: begin
          is_half_s = 1'b0;
          is_byte_s = 1'b0;
        end
      endcase
    end
  end

  assign misalign_s = access_s &
                      ((is_half_s & addr_lo_s[0]) |
                       (~is_half_s & ~is_byte_s & (addr_lo_s != 2'b00)));

  // EX/MEM is frozen during WAIT, so the request simply persists until ready.
  assign req_s   = ((state_q == S_IDLE) & access_s & ~misalign_s) | (state_q == S_WAIT);
  assign stall_s = req_s & ~DMemReady;

  always_comb begin
    byte_en_s    = 4'b0000;
    store_data_s = 32'h0000_0000;
    if (!req_s) begin
      byte_en_s    = 4'b0000;
      store_data_s = 32'h0000_0000;
    end else if (EXMEMMemWrite) begin
      if (is_byte_s) begin
        byte_en_s    = 4'b0001 << addr_lo_s;
        store_data_s = {4{EXMEMMemWriteData[7:0]}};
      end else if (is_half_s) begin
        byte_en_s    = addr_lo_s[1] ? 4'b1100 : 4'b0011;
        store_data_s = {2{EXMEMMemWriteData[15:0]}};
      end else begin
        byte_en_s    = 4'b1111;
        store_data_s = EXMEMMemWriteData;
      end
    end else begin
      byte_en_s    = 4'b1111;
      store_data_s = 32'h0000_0000;
    end
  end

  always_comb begin
    case (addr_lo_s)
      2'b00:   load_byte_s = DMemRData[7:0];
      2'b01:   load_byte_s = DMemRData[15:8];
      2'b10:   load_byte_s = DMemRData[23:16];
      2'b11:   load_byte_s = DMemRData[31:24];
      default: load_byte_s = DMemRData[7:0];
    endcase
    load_half_s = addr_lo_s[1] ? DMemRData[31:16] : DMemRData[15:0];
    case (EXMEMMemRBits)
      3'b001:  load_data_s = {{16{load_half_s[15]}}, load_half_s};
      3'b010:  load_data_s = {16'h0000, load_half_s};
      3'b011:  load_data_s = {{24{load_byte_s[7]}}, load_byte_s};
      3'b100:  load_data_s = {24'h00_0000, load_byte_s};
      default: load_data_s = DMemRData;
    endcase
    case (EXMEMMemtoReg)
      2'b01:   result_s = load_data_s;
      2'b10:   result_s = EXMEMPCPlus4;
      default: result_s = EXMEMALUResult;
    endcase
  end

  // Next state and MEM/WB contents; stalled or misaligned cycles become bubbles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_s && !DMemReady) state_d = S_WAIT;
        else                     state_d = S_IDLE;
      end
      S_WAIT: begin
        if (DMemReady) state_d = S_IDLE;
        else           state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase

    misalign_d = misalign_s;
    if (misalign_s || stall_s) begin
      instr_d    = 32'h0000_0000;
      wdata_d    = 32'h0000_0000;
      rd_d       = 5'd0;
      regwrite_d = 1'b0;
    end else begin
      instr_d    = EXMEMInstruction;
      wdata_d    = result_s;
      rd_d       = EXMEMRegRd;
      regwrite_d = EXMEMRegWrite;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      instr_q    <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      rd_q       <= 5'd0;
      regwrite_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      misalign_q <= misalign_d;
    end
  end

  // rst also gates the request so a reset arriving mid-WAIT drops it at once.
  assign DMemReq          = req_s & ~rst;
  assign DMemWe           = req_s & ~rst & EXMEMMemWrite;
  assign DMemAddr         = {EXMEMALUResult[31:2], 2'b00};
  assign DMemByteEn       = byte_en_s;
  assign DMemWData        = store_data_s;
  assign MEMStallReq      = stall_s & ~rst;
  assign MisalignErr      = misalign_q;
  assign MEMWBInstruction = instr_q;
  assign MEMWBWriteData   = wdata_q;
  assign MEMWBRegRd       = rd_q;
  assign MEMWBRegWrite    = regwrite_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, stores, delayed
// loads, misalignment, jal write-back and reset during an outstanding access.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] EXMEMInstruction, EXMEMPCPlus4, EXMEMALUResult, EXMEMMemWriteData;
  logic [4:0]  EXMEMRegRd;
  logic        EXMEMRegWrite, EXMEMMemWrite, EXMEMMemRead;
  logic [1:0]  EXMEMMemWrBits, EXMEMMemtoReg;
  logic [2:0]  EXMEMMemRBits;
  logic        DMemReq, DMemWe, DMemReady, MEMStallReq, MisalignErr;
  logic [31:0] DMemAddr, DMemWData, DMemRData;
  logic [3:0]  DMemByteEn;
  logic [31:0] MEMWBInstruction, MEMWBWriteData;
  logic [4:0]  MEMWBRegRd;
  logic        MEMWBRegWrite;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .EXMEMInstruction(EXMEMInstruction), .EXMEMPCPlus4(EXMEMPCPlus4),
    .EXMEMALUResult(EXMEMALUResult), .EXMEMMemWriteData(EXMEMMemWriteData),
    .EXMEMRegRd(EXMEMRegRd), .EXMEMRegWrite(EXMEMRegWrite),
    .EXMEMMemWrite(EXMEMMemWrite), .EXMEMMemWrBits(EXMEMMemWrBits),
    .EXMEMMemRead(EXMEMMemRead), .EXMEMMemRBits(EXMEMMemRBits),
    .EXMEMMemtoReg(EXMEMMemtoReg),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr),
    .DMemByteEn(DMemByteEn), .DMemWData(DMemWData),
    .DMemRData(DMemRData), .DMemReady(DMemReady),
    .MEMStallReq(MEMStallReq), .MisalignErr(MisalignErr),
    .MEMWBInstruction(MEMWBInstruction), .MEMWBWriteData(MEMWBWriteData),
    .MEMWBRegRd(MEMWBRegRd), .MEMWBRegWrite(MEMWBRegWrite)
  );

  task clear_inputs;
    EXMEMInstruction = 32'h0; EXMEMPCPlus4 = 32'h0; EXMEMALUResult = 32'h0;
    EXMEMMemWriteData = 32'h0; EXMEMRegRd = 5'd0; EXMEMRegWrite = 1'b0;
    EXMEMMemWrite = 1'b0; EXMEMMemWrBits = 2'b00; EXMEMMemRead = 1'b0;
    EXMEMMemRBits = 3'b000; EXMEMMemtoReg = 2'b00;
    DMemReady = 1'b0; DMemRData = 32'h0;
  endtask

  task test_reset;
    #12;
    checks++; if (MEMWBWriteData !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 00000000", MEMWBWriteData); end
    checks++; if (MEMWBRegWrite !== 1'b0) begin errors++; $display("FAIL rst_regwrite: got %b want 0", MEMWBRegWrite); end
    checks++; if (MEMWBInstruction !== 32'h0 || MEMWBRegRd !== 5'd0) begin errors++; $display("FAIL rst_instr_rd: got %h/%0d want 0/0", MEMWBInstruction, MEMWBRegRd); end
    checks++; if (MisalignErr !== 1'b0 || DMemReq !== 1'b0) begin errors++; $display("FAIL rst_err_req: got %b/%b want 0/0", MisalignErr, DMemReq); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task test_alu;
    EXMEMInstruction = 32'h0000_0033; EXMEMALUResult = 32'h0000_1234;
    EXMEMMemtoReg = 2'b00; EXMEMRegWrite = 1'b1; EXMEMRegRd = 5'd5;
    DMemReady = 1'b1; DMemRData = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (DMemReq !== 1'b0 || MEMStallReq !== 1'b0) begin errors++; $display("FAIL alu_req: got req=%b stall=%b want 0/0", DMemReq, MEMStallReq); end
    @(posedge clk); #1; clear_inputs();
    @(negedge clk);
    checks++; if (MEMWBWriteData !== 32'h0000_1234) begin errors++; $display("FAIL alu_wdata: got %h want 00001234", MEMWBWriteData); end
    checks++; if (MEMWBRegRd !== 5'd5 || MEMWBRegWrite !== 1'b1) begin errors++; $display("FAIL alu_rd: got rd=%0d we=%b want 5/1", MEMWBRegRd, MEMWBRegWrite); end
    checks++; if (MEMWBInstruction !== 32'h0000_0033) begin errors++; $display("FAIL alu_instr: got %h want 00000033", MEMWBInstruction); end
    @(posedge clk); #1;
  endtask

  task test_store;
    EXMEMInstruction = 32'h00A3_01A3; EXMEMALUResult = 32'h0000_0103;
    EXMEMMemWriteData = 32'h1234_56AB; EXMEMMemWrite = 1'b1; EXMEMMemWrBits = 2'b10;
    DMemReady = 1'b1;
    @(negedge clk);
    checks++; if (DMemReq !== 1'b1 || DMemWe !== 1'b1) begin errors++; $display("FAIL sb_req: got req=%b we=%b want 1/1", DMemReq, DMemWe); end
    checks++; if (DMemByteEn !== 4'b1000) begin errors++; $display("FAIL sb_ben: got %b want 1000", DMemByteEn); end
    checks++; if (DMemWData !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata: got %h want abababab", DMemWData); end
    checks++; if (DMemAddr !== 32'h0000_0100) begin errors++; $display("FAIL sb_addr: got %h want 00000100", DMemAddr); end
    checks++; if (MEMStallReq !== 1'b0) begin errors++; $display("FAIL sb_stall: got %b want 0", MEMStallReq); end
    @(posedge clk); #1; clear_inputs();
    @(negedge clk);
    checks++; if (MEMWBInstruction !== 32'h00A3_01A3 || MEMWBRegWrite !== 1'b0) begin errors++; $display("FAIL sb_memwb: got %h/%b want 00a301a3/0", MEMWBInstruction, MEMWBRegWrite); end
    @(posedge clk); #1;
  endtask

  task test_half_store;
    EXMEMALUResult = 32'h0000_0102; EXMEMMemWriteData = 32'h1234_ABCD;
    EXMEMMemWrite = 1'b1; EXMEMMemWrBits = 2'b01; DMemReady = 1'b1;
    @(negedge clk);
    checks++; if (DMemByteEn !== 4'b1100) begin errors++; $display("FAIL sh_ben: got %b want 1100", DMemByteEn); end
    checks++; if (DMemWData !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata: got %h want abcdabcd", DMemWData); end
    @(posedge clk); #1; clear_inputs();
  endtask

  task test_load_delay(input logic [2:0] kind, input logic [31:0] expected);
    EXMEMInstruction = 32'h0001_0383; EXMEMALUResult = 32'h0000_0102;
    EXMEMMemRead = 1'b1; EXMEMMemRBits = kind; EXMEMMemtoReg = 2'b01;
    EXMEMRegWrite = 1'b1; EXMEMRegRd = 5'd7; DMemReady = 1'b0; DMemRData = 32'hDEAD_BEEF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (DMemReq !== 1'b1 || MEMStallReq !== 1'b1) begin errors++; $display("FAIL ld_stall%0d: got req=%b stall=%b want 1/1", c, DMemReq, MEMStallReq); end
      checks++; if (DMemWe !== 1'b0 || DMemByteEn !== 4'b1111) begin errors++; $display("FAIL ld_we_ben%0d: got %b/%b want 0/1111", c, DMemWe, DMemByteEn); end
      checks++; if (MEMWBRegWrite !== 1'b0) begin errors++; $display("FAIL ld_bubble%0d: got %b want 0", c, MEMWBRegWrite); end
      @(posedge clk); #1;
    end
    DMemReady = 1'b1; DMemRData = 32'h0080_FF00;
    @(negedge clk);
    checks++; if (DMemReq !== 1'b1 || MEMStallReq !== 1'b0) begin errors++; $display("FAIL ld_ready: got req=%b stall=%b want 1/0", DMemReq, MEMStallReq); end
    @(posedge clk); #1; clear_inputs();
    @(negedge clk);
    checks++; if (MEMWBWriteData !== expected) begin errors++; $display("FAIL ld_data: got %h want %h", MEMWBWriteData, expected); end
    checks++; if (MEMWBRegWrite !== 1'b1 || MEMWBRegRd !== 5'd7) begin errors++; $display("FAIL ld_rd: got we=%b rd=%0d want 1/7", MEMWBRegWrite, MEMWBRegRd); end
    @(posedge clk); #1;
  endtask

  task test_misalign;
    EXMEMInstruction = 32'h1234_5678; EXMEMALUResult = 32'h0000_0101;
    EXMEMMemRead = 1'b1; EXMEMMemRBits = 3'b000; EXMEMMemtoReg = 2'b01;
    EXMEMRegWrite = 1'b1; EXMEMRegRd = 5'd9;
    @(negedge clk);
    checks++; if (DMemReq !== 1'b0 || MEMStallReq !== 1'b0) begin errors++; $display("FAIL mis_req: got req=%b stall=%b want 0/0", DMemReq, MEMStallReq); end
    @(posedge clk); #1; clear_inputs();
    @(negedge clk);
    checks++; if (MisalignErr !== 1'b1) begin errors++; $display("FAIL mis_err: got %b want 1", MisalignErr); end
    checks++; if (MEMWBRegWrite !== 1'b0 || MEMWBRegRd !== 5'd0 || MEMWBInstruction !== 32'h0) begin errors++; $display("FAIL mis_bubble: got we=%b rd=%0d ins=%h want 0/0/0", MEMWBRegWrite, MEMWBRegRd, MEMWBInstruction); end
    @(posedge clk); #1;
    EXMEMInstruction = 32'h0021_1483; EXMEMALUResult = 32'h0000_0102;
    EXMEMMemRead = 1'b1; EXMEMMemRBits = 3'b001; EXMEMMemtoReg = 2'b01;
    EXMEMRegWrite = 1'b1; EXMEMRegRd = 5'd9; DMemReady = 1'b1; DMemRData = 32'h8001_0000;
    @(negedge clk);
    checks++; if (MisalignErr !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b want 0", MisalignErr); end
    checks++; if (DMemReq !== 1'b1 || MEMStallReq !== 1'b0) begin errors++; $display("FAIL lh_req: got req=%b stall=%b want 1/0", DMemReq, MEMStallReq); end
    @(posedge clk); #1; clear_inputs();
    @(negedge clk);
    checks++; if (MEMWBWriteData !== 32'hFFFF_8001 || MEMWBRegWrite !== 1'b1) begin errors++; $display("FAIL lh_data: got %h/%b want ffff8001/1", MEMWBWriteData, MEMWBRegWrite); end
    checks++; if (MisalignErr !== 1'b0) begin errors++; $display("FAIL lh_err: got %b want 0", MisalignErr); end
    @(posedge clk); #1;
  endtask

  task test_jal;
    EXMEMInstruction = 32'h0100_00EF; EXMEMPCPlus4 = 32'h0000_0040;
    EXMEMALUResult = 32'h0000_0999; EXMEMMemtoReg = 2'b10;
    EXMEMRegWrite = 1'b1; EXMEMRegRd = 5'd1;
    @(posedge clk); #1; clear_inputs();
    @(negedge clk);
    checks++; if (MEMWBWriteData !== 32'h0000_0040 || MEMWBRegRd !== 5'd1) begin errors++; $display("FAIL jal_wdata: got %h rd=%0d want 00000040/1", MEMWBWriteData, MEMWBRegRd); end
    @(posedge clk); #1;
  endtask

  task test_reset_mid_wait;
    EXMEMInstruction = 32'h0000_2503; EXMEMALUResult = 32'h0000_0200;
    EXMEMMemRead = 1'b1; EXMEMMemRBits = 3'b000; EXMEMMemtoReg = 2'b01;
    EXMEMRegWrite = 1'b1; EXMEMRegRd = 5'd10; DMemReady = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (DMemReq !== 1'b1 || MEMStallReq !== 1'b1) begin errors++; $display("FAIL wait_req: got req=%b stall=%b want 1/1", DMemReq, MEMStallReq); end
    #2 rst = 1'b1;
    #1;
    checks++; if (DMemReq !== 1'b0 || MEMStallReq !== 1'b0) begin errors++; $display("FAIL arst_req: got req=%b stall=%b want 0/0", DMemReq, MEMStallReq); end
    checks++; if (MEMWBWriteData !== 32'h0 || MEMWBRegWrite !== 1'b0 || MEMWBRegRd !== 5'd0 || MEMWBInstruction !== 32'h0 || MisalignErr !== 1'b0) begin errors++; $display("FAIL arst_memwb: got %h/%b/%0d/%h/%b want all 0", MEMWBWriteData, MEMWBRegWrite, MEMWBRegRd, MEMWBInstruction, MisalignErr); end
    clear_inputs();
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (DMemReq !== 1'b0 || MEMStallReq !== 1'b0) begin errors++; $display("FAIL post_rst_idle: got req=%b stall=%b want 0/0", DMemReq, MEMStallReq); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_alu();
    test_store();
    test_half_store();
    test_load_delay(3'b011, 32'hFFFF_FF80);
    test_load_delay(3'b100, 32'h0000_0080);
    test_misalign();
    test_jal();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
